// File: rtl/sram_march_bist_ctrl_if.sv
// Bundle between the March C- BIST sequencer and its surroundings.
// It carries the test-controller side (start, status, first-fail log) and
// the SRAM macro BIST port (a_bist_* strobes/address/data, a_dout).
//   master : the sequencer (drives status and macro strobes, receives start/a_dout)
//   slave  : test controller plus macro (drives start/a_dout, observes the rest)
interface sram_march_bist_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
);
  logic              start;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [DATA_W-1:0] fail_data;
  logic [7:0]        err_cnt;
  logic              a_bist_en;
  logic              a_bist_men;
  logic              a_bist_wen;
  logic              a_bist_ren;
  logic [ADDR_W-1:0] a_bist_addr;
  logic [DATA_W-1:0] a_bist_din;
  logic [DATA_W-1:0] a_bist_bm;
  logic [DATA_W-1:0] a_dout;

  modport master (
    input  start, a_dout,
    output busy, done, fail, fail_addr, fail_elem, fail_data, err_cnt,
           a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr,
           a_bist_din, a_bist_bm
  );

  modport slave (
    output start, a_dout,
    input  busy, done, fail, fail_addr, fail_elem, fail_data, err_cnt,
           a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr,
           a_bist_din, a_bist_bm
  );
endinterface

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer for a single-port SRAM macro.
// Runs E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1), E4 down(r1,w0),
// E5 up(r0), one macro operation per cycle, and checks every read through a
// READ_LAT-deep compare pipeline. Logs first miscompare and a saturating count.
// Ports:
//   gclk  : clock (also the macro BIST clock)
//   grst  : synchronous active-high reset
//   bus   : master side of sram_march_bist_ctrl_if (start/status/log + macro port)
module sram_march_bist_ctrl #(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 64,
  parameter int                READ_LAT   = 1,
  parameter logic [DATA_W-1:0] BG_PATTERN = {DATA_W{1'b0}}
) (
  input logic                    gclk,
  input logic                    grst,
  sram_march_bist_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  // Operation currently on the macro port (elem/addr/phase) and the next one.
  logic [2:0]        elem, op_elem, seq_elem;
  logic [ADDR_W-1:0] addr, op_addr, seq_addr;
  logic              phase, op_phase, seq_phase;
  logic              op_vld, op_wr, dn, at_end, last_op, push, clr, done_nxt, miss;
  logic [DATA_W-1:0] wr_data, exp_in;

  // Compare pipeline: stage 0 loads at the edge the macro samples a read,
  // stage READ_LAT-1 is compared against a_dout.
  logic [READ_LAT-1:0]             vld_pipe, vld_nxt;
  logic [READ_LAT-1:0][DATA_W-1:0] exp_pipe;
  logic [READ_LAT-1:0][ADDR_W-1:0] addr_pipe;
  logic [READ_LAT-1:0][2:0]        elem_pipe;

  always_ff @(posedge gclk) begin
    if (grst) begin
      state <= S_IDLE;
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      elem  <= op_elem;
      addr  <= op_addr;
      phase <= op_phase;
    end
  end

  always_comb begin
    // Successor of the current operation in the march.
    dn        = (elem == 3'd3) || (elem == 3'd4);
    at_end    = dn ? (addr == '0) : (addr == '1);
    last_op   = (elem == 3'd5) && (addr == '1);
    seq_elem  = elem;
    seq_addr  = addr;
    seq_phase = 1'b0;
    if ((elem inside {[3'd1:3'd4]}) && !phase) begin
      seq_phase = 1'b1;                        // write follows read, same address
    end else if (at_end) begin
      seq_elem = elem + 3'd1;
      // E3 and E4 are the down elements and start at the top address.
      seq_addr = ((elem == 3'd2) || (elem == 3'd3)) ? '1 : '0;
    end else begin
      seq_addr = dn ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end

    // The read on the port right now is being sampled at this edge.
    push    = bus.a_bist_ren;
    vld_nxt = (vld_pipe << 1) | READ_LAT'(push);
    exp_in  = ((elem == 3'd2) || (elem == 3'd4)) ? ~BG_PATTERN : BG_PATTERN;

    state_nxt = state;
    done_nxt  = bus.done;
    clr       = 1'b0;
    op_vld    = 1'b0;
    op_elem   = elem;
    op_addr   = addr;
    op_phase  = phase;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt = S_RUN;
          done_nxt  = 1'b0;
          clr       = 1'b1;
          op_vld    = 1'b1;
          op_elem   = 3'd0;
          op_addr   = '0;
          op_phase  = 1'b0;
        end
      end
      S_RUN: begin
        if (last_op) begin
          state_nxt = S_DRAIN;
        end else begin
          op_vld   = 1'b1;
          op_elem  = seq_elem;
          op_addr  = seq_addr;
          op_phase = seq_phase;
        end
      end
      S_DRAIN: begin
        if (vld_nxt == '0) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    op_wr   = (op_elem == 3'd0) || op_phase;
    wr_data = ((op_elem == 3'd1) || (op_elem == 3'd3)) ? ~BG_PATTERN : BG_PATTERN;
  end

  // Registered status and macro strobes.
  always_ff @(posedge gclk) begin
    if (grst) begin
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.a_bist_en   <= 1'b0;
      bus.a_bist_men  <= 1'b0;
      bus.a_bist_wen  <= 1'b0;
      bus.a_bist_ren  <= 1'b0;
      bus.a_bist_addr <= '0;
      bus.a_bist_din  <= '0;
      bus.a_bist_bm   <= '0;
    end else begin
      bus.busy        <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      bus.a_bist_en   <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      bus.done        <= done_nxt;
      bus.a_bist_men  <= op_vld;
      bus.a_bist_wen  <= op_vld & op_wr;
      bus.a_bist_ren  <= op_vld & ~op_wr;
      bus.a_bist_addr <= op_vld ? op_addr : '0;
      bus.a_bist_din  <= (op_vld && op_wr) ? wr_data : '0;
      bus.a_bist_bm   <= {DATA_W{op_vld & op_wr}};
    end
  end

  assign miss = vld_pipe[READ_LAT-1] && (bus.a_dout != exp_pipe[READ_LAT-1]);

  // Compare pipeline and fail log.
  always_ff @(posedge gclk) begin
    if (grst) begin
      vld_pipe      <= '0;
      exp_pipe      <= '0;
      addr_pipe     <= '0;
      elem_pipe     <= '0;
      bus.fail      <= 1'b0;
      bus.fail_addr <= '0;
      bus.fail_elem <= '0;
      bus.fail_data <= '0;
      bus.err_cnt   <= '0;
    end else begin
      vld_pipe     <= vld_nxt;
      exp_pipe[0]  <= exp_in;
      addr_pipe[0] <= addr;
      elem_pipe[0] <= elem;
      for (int i = 1; i < READ_LAT; i++) begin
        exp_pipe[i]  <= exp_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
        elem_pipe[i] <= elem_pipe[i-1];
      end
      if (clr) begin
        bus.fail      <= 1'b0;
        bus.fail_addr <= '0;
        bus.fail_elem <= '0;
        bus.fail_data <= '0;
        bus.err_cnt   <= '0;
      end else if (miss) begin
        if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
        if (!bus.fail) begin
          bus.fail      <= 1'b1;
          bus.fail_addr <= addr_pipe[READ_LAT-1];
          bus.fail_elem <= elem_pipe[READ_LAT-1];
          bus.fail_data <= bus.a_dout ^ exp_pipe[READ_LAT-1];
        end
      end
    end
  end

endmodule
